cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/load sequencer for the FRANK6000 CPU core. Sits between the debounced
//  switches / UART instruction receiver and the CPU. Generates the program
//  write address and write-enable during LOAD, and gates the CPU run enable
//  (RUN, single-STEP, PAUSE). Auto-halts when the CPU reports its terminal loop.
// PARAMETERS
//  ADDR_W      8    width of the instruction address bus to the CPU
//  PROG_DEPTH  256  number of program slots; must be <= 2**ADDR_W
// PORTS
//  i_clk         in   1        system clock (25 MHz)
//  i_rst_n       in   1        reset, asynchronous, active-low
//  i_rx_dv       in   1        1-cycle pulse: a 16-bit instruction word is valid
//  i_run_sw      in   1        debounced run/stop switch level
//  i_step_sw     in   1        debounced single-step switch level
//  i_loopf       in   1        CPU terminal-loop flag
//  o_instr_addr  out  ADDR_W   CPU program write address
//  o_we          out  1        CPU program write enable
//  o_cpu_on      out  1        CPU execute enable
//  o_prog_len    out  ADDR_W+1 instruction count latched when leaving LOAD
//  o_ovf         out  1        sticky: a write was dropped because the program was full
//  o_state       out  3        current FSM state (drives LEDs / debug)
// BEHAVIOUR
//  Reset (async assert, sync release): state=LOAD, count=0, o_prog_len=0,
//    o_ovf=0, edge registers=0. o_we=0, o_cpu_on=0.
//  Switch events: falling edge of a debounced level (prev=1, now=0); the
//    previous-value register resets to 0. Events are 1 cycle long, occur 1 cycle
//    after the level falls. Simultaneous run+step events: run wins, step dropped.
//  count: ADDR_W+1 bits. o_instr_addr = count[ADDR_W-1:0] in every state.
//  States (encoding 0..4):
//    LOAD:  o_we = i_rx_dv & (count < PROG_DEPTH), combinational (0 latency,
//           same cycle as i_rx_dv, addr = current count). count+1 on that edge.
//           i_rx_dv while count==PROG_DEPTH: no write, o_ovf<=1.
//           run evt: count==0 -> ignored; else o_prog_len<=count, ->RUN.
//           step evt: count==0 -> ignored; else o_prog_len<=count, ->STEP.
//    RUN:   o_cpu_on=1. i_loopf -> HALT (priority over events).
//           run evt -> PAUSE.
//    PAUSE: o_cpu_on=0. run evt -> RUN; step evt -> STEP.
//    STEP:  o_cpu_on=1 for exactly one cycle; next state PAUSE, or HALT if
//           i_loopf is high in that cycle. Events in STEP are dropped.
//    HALT:  o_cpu_on=0. run evt -> LOAD. step evt ignored.
//  Entering LOAD from HALT: count<=0 and o_ovf<=0 on the transition edge;
//    o_prog_len holds until the next LOAD exit.
//  i_rx_dv outside LOAD: ignored; o_we=0, count unchanged (the UART may keep
//    streaming while the CPU runs).
//  i_loopf outside RUN/STEP: ignored.
//  Reset mid-operation (any state): immediate return to reset values.
// STRUCTURE
//  Shared package/header frank_pkg: state localparams ST_LOAD=3'd0, ST_RUN=3'd1,
//    ST_PAUSE=3'd2, ST_STEP=3'd3, ST_HALT=3'd4 (also used by LED/debug logic).
//  Sub-module: fall_edge_det (1 reg + AND), instantiated for run and step.
//  Single always block for FSM/count/flags; o_we and o_cpu_on decoded from state.
// TESTING
//  1. Reset, 3 rx_dv pulses -> o_we pulses at addr 0,1,2; run evt -> RUN,
//     o_prog_len=3, o_cpu_on=1 on the next cycle.
//  2. Run evt with count=0 -> state stays LOAD, o_cpu_on stays 0.
//  3. PROG_DEPTH=4: 5 rx_dv pulses -> 4 writes (addr 0..3), 5th gives o_we=0,
//     o_ovf=1, count=4.
//  4. LOAD(2 instr) -> step evt -> o_cpu_on high exactly 1 cycle -> PAUSE;
//     2 more steps -> 2 single-cycle pulses; run evt -> RUN.
//  5. RUN, assert i_loopf -> HALT next cycle, o_cpu_on=0; run evt -> LOAD,
//     count=0, o_ovf=0; rx_dv during RUN produced no o_we.
//  6. Run+step falling edges in the same cycle in PAUSE -> RUN; i_rst_n low
//     mid-RUN -> immediate LOAD, all outputs at reset values.

Source files
------------

// File: rtl/frank_pkg.sv
// rtl/frank_pkg.sv - shared FRANK6000 run-controller state encoding
// Contents: state_e, the run/load sequencer state. The same values are
// decoded by the LED/debug logic, so the encoding is fixed at 0..4.
package frank_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_STEP  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

endpackage

// File: rtl/fall_edge_det.sv
// rtl/fall_edge_det.sv - falling-edge event detector for a debounced switch level
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   level in   debounced switch level
//   evt   out  high for the one cycle in which level is 0 and was 1 last cycle
module fall_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic evt
);

    logic prev;

    // prev resets to 0 so a switch held low through reset never
    // produces a spurious event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign evt = prev & ~level;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - FRANK6000 run/load sequencer (LOAD, RUN, STEP, PAUSE, HALT)
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_rx_dv         one-cycle pulse: an instruction word is valid
//   i_run_sw        debounced run/stop switch level
//   i_step_sw       debounced single-step switch level
//   i_loopf         CPU terminal-loop flag
//   o_instr_addr    program write address (low bits of the load count)
//   o_we            program write enable
//   o_cpu_on        CPU execute enable
//   o_prog_len      instruction count latched when leaving LOAD
//   o_ovf           sticky: a write was dropped because the program was full
//   o_state         current state
import frank_pkg::*;

module cpu_run_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int PROG_DEPTH = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_dv,
    input  logic              i_run_sw,
    input  logic              i_step_sw,
    input  logic              i_loopf,
    output logic [ADDR_W-1:0] o_instr_addr,
    output logic              o_we,
    output logic              o_cpu_on,
    output logic [ADDR_W:0]   o_prog_len,
    output logic              o_ovf,
    output logic [2:0]        o_state
);

    localparam logic [ADDR_W:0] DEPTH = PROG_DEPTH[ADDR_W:0];

    state_e          state, state_n;
    logic [ADDR_W:0] count, count_n;
    logic [ADDR_W:0] prog_len_n;
    logic            ovf_n;
    logic            run_evt, step_raw, step_evt;
    logic            has_room;

    fall_edge_det u_run_edge (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .level (i_run_sw),
        .evt   (run_evt)
    );

    fall_edge_det u_step_edge (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .level (i_step_sw),
        .evt   (step_raw)
    );

    // Run wins when both switches are released in the same cycle.
    assign step_evt = step_raw & ~run_evt;
    assign has_room = (count < DEPTH);

    always_comb begin
        state_n    = state;
        count_n    = count;
        prog_len_n = o_prog_len;
        ovf_n      = o_ovf;
        case (state)
            ST_LOAD: begin
                if (i_rx_dv) begin
                    if (has_room) begin
                        count_n = count + 1'b1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
                // An empty program cannot be started.
                if (count != '0) begin
                    if (run_evt) begin
                        prog_len_n = count;
                        state_n    = ST_RUN;
                    end else if (step_evt) begin
                        prog_len_n = count;
                        state_n    = ST_STEP;
                    end
                end
            end
            ST_RUN: begin
                if (i_loopf) begin
                    state_n = ST_HALT;
                end else if (run_evt) begin
                    state_n = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (run_evt) begin
                    state_n = ST_RUN;
                end else if (step_evt) begin
                    state_n = ST_STEP;
                end
            end
            ST_STEP: begin
                state_n = i_loopf ? ST_HALT : ST_PAUSE;
            end
            ST_HALT: begin
                if (run_evt) begin
                    state_n = ST_LOAD;
                    count_n = '0;
                    ovf_n   = 1'b0;
                end
            end
            default: begin
                state_n = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_LOAD;
            count      <= '0;
            o_prog_len <= '0;
            o_ovf      <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            o_prog_len <= prog_len_n;
            o_ovf      <= ovf_n;
        end
    end

    // o_we is combinational with i_rx_dv; reset gates it so a UART pulse
    // arriving while reset is held cannot write the program memory.
    assign o_we         = i_rst_n & (state == ST_LOAD) & i_rx_dv & has_room;
    assign o_cpu_on     = (state == ST_RUN) | (state == ST_STEP);
    assign o_instr_addr = count[ADDR_W-1:0];
    assign o_state      = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    localparam int S_LOAD  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_STEP  = 3;
    localparam int S_HALT  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_dv, run_sw, step_sw, loopf;
    logic [AW-1:0] instr_addr;
    logic          we, cpu_on, ovf;
    logic [AW:0]   prog_len;
    logic [2:0]    state;

    int vectors     = 0;
    int miscompares = 0;

    // reference model
    int m_state, m_cnt, m_len;
    bit m_ovf, m_prun, m_pstep;

    cpu_run_ctrl #(.ADDR_W(AW), .PROG_DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_dv      (rx_dv),
        .i_run_sw     (run_sw),
        .i_step_sw    (step_sw),
        .i_loopf      (loopf),
        .o_instr_addr (instr_addr),
        .o_we         (we),
        .o_cpu_on     (cpu_on),
        .o_prog_len   (prog_len),
        .o_ovf        (ovf),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_LOAD;
        m_cnt   = 0;
        m_len   = 0;
        m_ovf   = 0;
        m_prun  = 0;
        m_pstep = 0;
    endtask

    task automatic model_step();
        bit rev, sev;
        int c0;
        rev = m_prun && !run_sw;
        sev = m_pstep && !step_sw && !rev;
        c0  = m_cnt;
        case (m_state)
            S_LOAD: begin
                if (rx_dv) begin
                    if (c0 < DEPTH) m_cnt = c0 + 1;
                    else            m_ovf = 1;
                end
                if (c0 != 0 && (rev || sev)) begin
                    m_len   = c0;
                    m_state = rev ? S_RUN : S_STEP;
                end
            end
            S_RUN:   if (loopf) m_state = S_HALT; else if (rev) m_state = S_PAUSE;
            S_PAUSE: if (rev) m_state = S_RUN; else if (sev) m_state = S_STEP;
            S_STEP:  m_state = loopf ? S_HALT : S_PAUSE;
            S_HALT:  if (rev) begin m_state = S_LOAD; m_cnt = 0; m_ovf = 0; end
            default: m_state = S_LOAD;
        endcase
        m_prun  = run_sw;
        m_pstep = step_sw;
    endtask

    task automatic compare_all();
        bit exp_we;
        exp_we = rst_n && m_state == S_LOAD && rx_dv && m_cnt < DEPTH;
        chk("m_state",  state,      m_state);
        chk("m_addr",   instr_addr, m_cnt % (1 << AW));
        chk("m_we",     we,         exp_we);
        chk("m_cpu_on", cpu_on,     (m_state == S_RUN || m_state == S_STEP));
        chk("m_len",    prog_len,   m_len);
        chk("m_ovf",    ovf,        m_ovf);
    endtask

    // One clock: compare at the falling edge, advance the model at the
    // rising edge, then return 1 time unit later so inputs change away
    // from the edge.
    task automatic tick();
        if (!rst_n) model_reset();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
    endtask

    // Raise the selected switches for a cycle, release them; the release
    // cycle carries the event, consumed at the end of the second tick.
    task automatic press(input bit r, input bit s);
        run_sw  = r;
        step_sw = s;
        tick();
        run_sw  = 1'b0;
        step_sw = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; rx_dv = 1'b0; run_sw = 1'b0; step_sw = 1'b0; loopf = 1'b0;
        model_reset();
        #2;
        chk("rst_state", state, S_LOAD);
        chk("rst_we", we, 0);
        chk("rst_cpu_on", cpu_on, 0);
        chk("rst_len", prog_len, 0);
        chk("rst_ovf", ovf, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: three writes at addresses 0,1,2 then run
        rx_dv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t1_we", we, 1);
            chk("t1_addr", instr_addr, i);
            tick();
        end
        rx_dv = 1'b0;
        press(1, 0);
        #1;
        chk("t1_state", state, S_RUN);
        chk("t1_len", prog_len, 3);
        chk("t1_cpu_on", cpu_on, 1);

        // 5: rx_dv during RUN is ignored, loopf halts, run reloads
        rx_dv = 1'b1;
        #1;
        chk("t5_we_run", we, 0);
        tick();
        rx_dv = 1'b0;
        loopf = 1'b1;
        tick();
        loopf = 1'b0;
        #1;
        chk("t5_halt", state, S_HALT);
        chk("t5_cpu_on", cpu_on, 0);
        chk("t5_addr_kept", instr_addr, 3);
        press(1, 0);
        #1;
        chk("t5_load", state, S_LOAD);
        chk("t5_addr0", instr_addr, 0);
        chk("t5_len_held", prog_len, 3);

        // 2: run with an empty program is ignored
        press(1, 0);
        #1;
        chk("t2_state", state, S_LOAD);
        chk("t2_cpu_on", cpu_on, 0);

        // 3: five writes into a four-slot program
        rx_dv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_we", we, (i < 4));
            chk("t3_addr", instr_addr, i % 4);
            tick();
        end
        rx_dv = 1'b0;
        #1;
        chk("t3_ovf", ovf, 1);
        chk("t3_state", state, S_LOAD);

        // back to an empty LOAD, then 4: two instructions, single stepping
        press(1, 0);
        loopf = 1'b1;
        tick();
        loopf = 1'b0;
        press(1, 0);
        #1;
        chk("t4_ovf_clr", ovf, 0);
        rx_dv = 1'b1;
        tick();
        tick();
        rx_dv = 1'b0;
        press(0, 1);
        #1;
        chk("t4_step", state, S_STEP);
        chk("t4_on", cpu_on, 1);
        tick();
        #1;
        chk("t4_pause", state, S_PAUSE);
        chk("t4_off", cpu_on, 0);
        chk("t4_len", prog_len, 2);
        for (int i = 0; i < 2; i++) begin
            press(0, 1);
            #1;
            chk("t4_pulse_on", cpu_on, 1);
            tick();
            #1;
            chk("t4_pulse_off", cpu_on, 0);
        end
        press(1, 0);
        #1;
        chk("t4_run", state, S_RUN);

        // 6: simultaneous run+step in PAUSE goes to RUN; reset mid-RUN
        press(1, 0);
        #1;
        chk("t6_pause", state, S_PAUSE);
        press(1, 1);
        #1;
        chk("t6_run", state, S_RUN);
        rx_dv = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_state", state, S_LOAD);
        chk("t6_rst_on", cpu_on, 0);
        chk("t6_rst_we", we, 0);
        chk("t6_rst_len", prog_len, 0);
        chk("t6_rst_addr", instr_addr, 0);
        tick();
        rst_n = 1'b1;
        rx_dv = 1'b0;

        // randomized traffic checked against the model every cycle
        for (int n = 0; n < 4000; n++) begin
            rx_dv   = ($urandom_range(0, 1) == 1);
            run_sw  = ($urandom_range(0, 3) == 0);
            step_sw = ($urandom_range(0, 3) == 0);
            loopf   = ($urandom_range(0, 9) == 0);
            rst_n   = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
